// File: rtl/gbuff_out_writer.sv
// gbuff_out_writer
//   Write-back stage from the systolic array into GBUFF_OUT. Each accepted
//   beat carries one result row slice of NUM_LANES accumulator lanes. Every
//   lane is truncated to DATA_SIZE bits and the lanes are packed into one
//   gbuff word. The word is written at tile*m + row, one cycle after the
//   beat is accepted. done pulses for one cycle in the same cycle as the
//   final write.
//
//   Ports
//     clk, rst     rising-edge clock, synchronous active-high reset
//     start        1-cycle pulse that begins one m x n matrix (ignored unless idle)
//     m, n         result rows / cols, sampled on start
//     in_valid     row beat valid
//     in_data      lane j at [j*ACC_W +: ACC_W]
//     in_ready     high while running (depends on state only)
//     wr_en        GBUFF_OUT write strobe
//     wr_addr      GBUFF_OUT word address (wraps modulo 2^ADDR_W)
//     wr_data      lane j at [j*DATA_SIZE +: DATA_SIZE]
//     done         1-cycle completion pulse

// One output lane: keeps the low DATA_SIZE bits of the accumulator, or
// forces zero for the padding columns of a partial last tile.
module gbuff_out_lane #(
    parameter int DATA_SIZE = 8,
    parameter int ACC_W     = 16
) (
    input  logic [ACC_W-1:0]     acc,
    input  logic                 en,
    output logic [DATA_SIZE-1:0] q
);
    assign q = en ? acc[DATA_SIZE-1:0] : '0;

    // Upper accumulator bits are dropped on purpose (truncation, not saturation).
    generate
        if (ACC_W > DATA_SIZE) begin : g_hi
            logic unused_hi;
            assign unused_hi = ^acc[ACC_W-1:DATA_SIZE];
        end
    endgenerate
endmodule

module gbuff_out_writer #(
    parameter int DATA_SIZE = 8,
    parameter int ACC_W     = 16,
    parameter int ADDR_W    = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [3:0]             m,
    input  logic [3:0]             n,
    input  logic                   in_valid,
    input  logic [4*ACC_W-1:0]     in_data,
    output logic                   in_ready,
    output logic                   wr_en,
    output logic [ADDR_W-1:0]      wr_addr,
    output logic [4*DATA_SIZE-1:0] wr_data,
    output logic                   done
);
    localparam int NUM_LANES = 4;

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t     state_q, state_d;
    logic [3:0] m_r;
    logic [1:0] rem_r;      // n % 4 of the current matrix
    logic [2:0] tiles_r;    // ceil(n / 4)
    logic [3:0] row;
    logic [2:0] tile;

    logic accept, row_last, tile_last, zero_dim;
    logic [2:0] tiles_c;
    logic [ADDR_W-1:0] addr_c;

    logic [NUM_LANES-1:0][ACC_W-1:0]     lane_acc;
    logic [NUM_LANES-1:0][DATA_SIZE-1:0] lane_q;
    logic [NUM_LANES-1:0]                lane_en;

    assign accept    = in_valid && (state_q == RUN);
    assign row_last  = (row == m_r - 4'd1);
    assign tile_last = (tile == tiles_r - 3'd1);
    assign zero_dim  = (m == 4'd0) || (n == 4'd0);
    assign tiles_c   = 3'((5'(n) + 5'd3) >> 2);
    assign addr_c    = ADDR_W'(tile) * ADDR_W'(m_r) + ADDR_W'(row);
    assign lane_acc  = in_data;

    // Lanes past n%4 in the last tile are padding columns and are written as 0.
    genvar j;
    generate
        for (j = 0; j < NUM_LANES; j++) begin : g_lane
            localparam logic [2:0] LJ = 3'(j);
            assign lane_en[j] = !(tile_last && (rem_r != 2'd0) && (LJ >= {1'b0, rem_r}));
            gbuff_out_lane #(.DATA_SIZE(DATA_SIZE), .ACC_W(ACC_W)) u_lane (
                .acc (lane_acc[j]),
                .en  (lane_en[j]),
                .q   (lane_q[j])
            );
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = zero_dim ? FIN : RUN;
            RUN:  if (accept && row_last && tile_last) state_d = FIN;
            FIN:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign in_ready = (state_q == RUN);
    assign done     = (state_q == FIN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            m_r     <= '0;
            rem_r   <= '0;
            tiles_r <= '0;
            row     <= '0;
            tile    <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            state_q <= state_d;
            wr_en   <= accept;
            if (state_q == IDLE && start) begin
                m_r     <= m;
                rem_r   <= n[1:0];
                tiles_r <= tiles_c;
                row     <= '0;
                tile    <= '0;
            end
            if (accept) begin
                wr_addr <= addr_c;
                wr_data <= lane_q;
                if (row_last) begin
                    row  <= '0;
                    tile <= tile + 3'd1;
                end else begin
                    row  <= row + 4'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_gbuff_out_writer.sv
// tb_gbuff_out_writer
//   Directed bench for gbuff_out_writer: a table of back-to-back beats with
//   hand-computed write addresses/data, plus sequences for gapped input,
//   zero-size matrices, start during RUN and mid-run reset.
module tb_gbuff_out_writer;
    logic        clk, rst, start, in_valid;
    logic [3:0]  m, n;
    logic [63:0] in_data;
    logic        in_ready, wr_en, done;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;

    int n_checks = 0;
    int n_fail   = 0;

    gbuff_out_writer #(.DATA_SIZE(8), .ACC_W(16), .ADDR_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .m(m), .n(n),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        new_mat;   // pulse start with m,n before this beat
        logic [3:0]  m, n;
        logic [63:0] data;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic        last;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge: pulse start for one cycle, then check the resulting state.
    task automatic do_start(input logic [3:0] mm, input logic [3:0] nn, input logic exp_ready);
        start = 1'b1; m = mm; n = nn;
        @(negedge clk);
        start = 1'b0;
        check("start_in_ready", 64'(in_ready), 64'(exp_ready));
    endtask

    // Called at a negedge: present one beat, then check its write one cycle later.
    task automatic beat(input logic [63:0] d, input logic [7:0] ea, input logic [31:0] ed, input logic edone);
        in_valid = 1'b1; in_data = d;
        @(negedge clk);
        check("wr_en",   64'(wr_en),   64'd1);
        check("wr_addr", 64'(wr_addr), 64'(ea));
        check("wr_data", 64'(wr_data), 64'(ed));
        check("done",    64'(done),    64'(edone));
    endtask

    // Called at the negedge after a final write: expect idle with outputs held.
    task automatic check_idle(input logic [7:0] ha, input logic [31:0] hd);
        in_valid = 1'b0;
        @(negedge clk);
        check("idle_wr_en",    64'(wr_en),    64'd0);
        check("idle_done",     64'(done),     64'd0);
        check("idle_in_ready", 64'(in_ready), 64'd0);
        check("idle_addr",     64'(wr_addr),  64'(ha));
        check("idle_data",     64'(wr_data),  64'(hd));
    endtask

    initial begin
        // m=4,n=4 basic packing
        vecs[0]  = '{1'b1, 4'd4, 4'd4, 64'h0078_0056_0034_0012, 8'd0, 32'h78563412, 1'b0};
        vecs[1]  = '{1'b0, 4'd4, 4'd4, 64'h0078_0056_0034_0012, 8'd1, 32'h78563412, 1'b0};
        vecs[2]  = '{1'b0, 4'd4, 4'd4, 64'h0078_0056_0034_0012, 8'd2, 32'h78563412, 1'b0};
        vecs[3]  = '{1'b0, 4'd4, 4'd4, 64'h0078_0056_0034_0012, 8'd3, 32'h78563412, 1'b1};
        // truncation: 0x1FF->FF, 0xFF80->80, 0xABCD->CD, 0x0100->00
        vecs[4]  = '{1'b1, 4'd1, 4'd4, 64'h0100_ABCD_FF80_01FF, 8'd0, 32'h00CD80FF, 1'b1};
        // m=2,n=6: two tiles, tile-1 lanes 2,3 zeroed
        vecs[5]  = '{1'b1, 4'd2, 4'd6, 64'h0004_0003_0002_0001, 8'd0, 32'h04030201, 1'b0};
        vecs[6]  = '{1'b0, 4'd2, 4'd6, 64'h0014_0013_0012_0011, 8'd1, 32'h14131211, 1'b0};
        vecs[7]  = '{1'b0, 4'd2, 4'd6, 64'h0024_0023_0022_0021, 8'd2, 32'h00002221, 1'b0};
        vecs[8]  = '{1'b0, 4'd2, 4'd6, 64'h0034_0033_0032_0031, 8'd3, 32'h00003231, 1'b1};
        // m=3,n=5: address tile*3+row, last tile keeps lane 0 only
        vecs[9]  = '{1'b1, 4'd3, 4'd5, 64'h1111_2222_3333_4444, 8'd0, 32'h11223344, 1'b0};
        vecs[10] = '{1'b0, 4'd3, 4'd5, 64'h5555_6666_7777_8888, 8'd1, 32'h55667788, 1'b0};
        vecs[11] = '{1'b0, 4'd3, 4'd5, 64'h9999_AAAA_BBBB_CCCC, 8'd2, 32'h99AABBCC, 1'b0};
        vecs[12] = '{1'b0, 4'd3, 4'd5, 64'hDDDD_EEEE_FFFF_0101, 8'd3, 32'h00000001, 1'b0};
        vecs[13] = '{1'b0, 4'd3, 4'd5, 64'h1234_5678_9ABC_DEF0, 8'd4, 32'h000000F0, 1'b0};
        vecs[14] = '{1'b0, 4'd3, 4'd5, 64'hFFFF_FFFF_FFFF_FF7F, 8'd5, 32'h0000007F, 1'b1};

        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; m = '0; n = '0;
        repeat (2) @(negedge clk);
        check("rst_wr_en",    64'(wr_en),    64'd0);
        check("rst_done",     64'(done),     64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_wr_addr",  64'(wr_addr),  64'd0);
        check("rst_wr_data",  64'(wr_data),  64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Back-to-back table: in_valid stays high across consecutive beats.
        for (int i = 0; i < 15; i++) begin
            if (vecs[i].new_mat) do_start(vecs[i].m, vecs[i].n, 1'b1);
            beat(vecs[i].data, vecs[i].addr, vecs[i].wdata, vecs[i].last);
            if (vecs[i].last) check_idle(vecs[i].addr, vecs[i].wdata);
        end

        // in_valid toggling: writes only after accepted beats, outputs held in gaps.
        do_start(4'd4, 4'd4, 1'b1);
        for (int i = 0; i < 4; i++) begin
            beat({4{16'(8'hA0 + 8'(i))}}, 8'(i), {4{8'hA0 + 8'(i)}}, i == 3);
            in_valid = 1'b0; in_data = 64'hFFFF_FFFF_FFFF_FFFF;
            @(negedge clk);
            check("gap_wr_en",   64'(wr_en),   64'd0);
            check("gap_wr_addr", 64'(wr_addr), 64'(i));
            check("gap_wr_data", 64'(wr_data), 64'({4{8'hA0 + 8'(i)}}));
        end

        // m=0: straight to FIN, no writes even with in_valid high.
        in_valid = 1'b1;
        do_start(4'd0, 4'd3, 1'b0);
        check("zero_done",  64'(done),  64'd1);
        check("zero_wr_en", 64'(wr_en), 64'd0);
        @(negedge clk);
        check("zero_done_off", 64'(done),  64'd0);
        check("zero_wr_en2",   64'(wr_en), 64'd0);
        in_valid = 1'b0;

        // start during RUN is ignored: m stays 2.
        do_start(4'd2, 4'd4, 1'b1);
        beat(64'h0001_0002_0003_0004, 8'd0, 32'h01020304, 1'b0);
        start = 1'b1; m = 4'd4; n = 4'd8;
        beat(64'h0005_0006_0007_0008, 8'd1, 32'h05060708, 1'b1);
        start = 1'b0;
        check_idle(8'd1, 32'h05060708);

        // Reset after 2 of 4 beats, then a clean rerun.
        do_start(4'd4, 4'd4, 1'b1);
        beat(64'h0011_0022_0033_0044, 8'd0, 32'h11223344, 1'b0);
        beat(64'h0055_0066_0077_0088, 8'd1, 32'h55667788, 1'b0);
        in_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        check("rrst_wr_en",    64'(wr_en),    64'd0);
        check("rrst_done",     64'(done),     64'd0);
        check("rrst_in_ready", 64'(in_ready), 64'd0);
        rst = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        check("post_rst_wr_en",    64'(wr_en),    64'd0);
        check("post_rst_in_ready", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
        do_start(4'd4, 4'd4, 1'b1);
        for (int i = 0; i < 4; i++)
            beat(64'h0078_0056_0034_0012, 8'(i), 32'h78563412, i == 3);
        check_idle(8'd3, 32'h78563412);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
